writeback_stage: RTL and testbench

Final pipeline stage of the RISCV-Lite core, directly downstream of the memory stage. It registers the MEM/WB pipeline state and takes the data-SRAM read word on the cycle after the read. It extracts and sign/zero-extends the load sub-word, selects the write-back source, and drives the register-file write port. It also counts retired instructions and flags a sticky halt on EBREAK, keeping load data correct across pipeline stalls.

---
 rtl/writeback_stage.sv | 167 ++++++++++++++++
 tb/tb_writeback_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final stage of the RISCV-Lite pipeline. Registers MEM/WB state, picks
//   load data from the SRAM read word (live) or a hold copy (after a stall),
//   extracts/extends the load sub-word, muxes the write-back source and drives
//   the register-file write port. Also counts retired instructions and keeps
//   a sticky halt flag raised by HALT_INSTR.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   EN, START           stage advances on an edge when EN & START
//   MEM_in_*            MEM/WB pipeline inputs (valid, RegWrite, MemToReg,
//                       funct3, rd, ALU_res, PC_plus4, instr)
//   MEM_mem_data        SRAM dout, valid in the cycle after the read edge
//   WB_rf_we/waddr/wdata register-file write port (wdata also forwarded)
//   WB_instr            instruction currently in WB
//   WB_retire_cnt       retired valid instruction count (wraps)
//   WB_halt             sticky halt flag
module writeback_stage #(
    parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        START,
    input  logic        MEM_in_valid,
    input  logic        MEM_in_RegWrite,
    input  logic [1:0]  MEM_in_MemToReg,
    input  logic [2:0]  MEM_in_funct3,
    input  logic [4:0]  MEM_in_rd,
    input  logic [31:0] MEM_in_ALU_res,
    input  logic [31:0] MEM_in_PC_plus4,
    input  logic [31:0] MEM_in_instr,
    input  logic [31:0] MEM_mem_data,
    output logic        WB_rf_we,
    output logic [4:0]  WB_rf_waddr,
    output logic [31:0] WB_rf_wdata,
    output logic [31:0] WB_instr,
    output logic [31:0] WB_retire_cnt,
    output logic        WB_halt
);

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LIVE = 2'd1,
        LD_HELD = 2'd2
    } ld_state_t;

    logic        adv;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [1:0]  wb_memtoreg;
    logic [2:0]  wb_funct3;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_res;
    logic [31:0] wb_pc_plus4;
    logic [31:0] wb_instr_q;
    logic [31:0] hold_data;
    logic [31:0] retire_cnt;
    logic        halt_q;

    ld_state_t   state, next_state;
    logic        hold_load;

    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign adv = EN & START;

    // Load-data source FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state <= LD_IDLE;
        else     state <= next_state;
    end

    // A stall while the load is live must snapshot dout, since the SRAM
    // output is only guaranteed for the single cycle after the read edge.
    always_comb begin
        next_state = state;
        hold_load  = 1'b0;
        if (adv) begin
            if (MEM_in_valid && MEM_in_MemToReg == 2'b01) next_state = LD_LIVE;
            else                                          next_state = LD_IDLE;
        end else if (state == LD_LIVE) begin
            hold_load  = 1'b1;
            next_state = LD_HELD;
        end
    end

    // Pipeline register, hold register, retire counter, halt flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 2'b00;
            wb_funct3   <= 3'b000;
            wb_rd       <= 5'd0;
            wb_alu_res  <= 32'd0;
            wb_pc_plus4 <= 32'd0;
            wb_instr_q  <= 32'd0;
            hold_data   <= 32'd0;
            retire_cnt  <= 32'd0;
            halt_q      <= 1'b0;
        end else begin
            if (adv) begin
                wb_valid    <= MEM_in_valid;
                wb_regwrite <= MEM_in_RegWrite;
                wb_memtoreg <= MEM_in_MemToReg;
                wb_funct3   <= MEM_in_funct3;
                wb_rd       <= MEM_in_rd;
                wb_alu_res  <= MEM_in_ALU_res;
                wb_pc_plus4 <= MEM_in_PC_plus4;
                wb_instr_q  <= MEM_in_instr;
                // An instruction retires as it leaves WB
                if (wb_valid) retire_cnt <= retire_cnt + 32'd1;
                if (wb_valid && wb_instr_q == HALT_INSTR) halt_q <= 1'b1;
            end
            if (hold_load) hold_data <= MEM_mem_data;
        end
    end

    // Sub-word extraction
    assign ld_word = (state == LD_HELD) ? hold_data : MEM_mem_data;

    always_comb begin
        ld_byte = ld_word[7:0];
        case (wb_alu_res[1:0])
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
    end

    assign ld_half = wb_alu_res[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_ext = ld_word;
        case (wb_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = ld_word;
        endcase
    end

    // Write-back source select; 11 falls back to the ALU result
    always_comb begin
        WB_rf_wdata = wb_alu_res;
        case (wb_memtoreg)
            2'b01:   WB_rf_wdata = ld_ext;
            2'b10:   WB_rf_wdata = wb_pc_plus4;
            default: WB_rf_wdata = wb_alu_res;
        endcase
    end

    // Held asserted through stalls; rewriting the same value is harmless
    assign WB_rf_we      = wb_valid & wb_regwrite & (wb_rd != 5'd0);
    assign WB_rf_waddr   = wb_rd;
    assign WB_instr      = wb_instr_q;
    assign WB_retire_cnt = retire_cnt;
    assign WB_halt       = halt_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        CLK = 1'b0;
    logic        RST, EN, START;
    logic        MEM_in_valid, MEM_in_RegWrite;
    logic [1:0]  MEM_in_MemToReg;
    logic [2:0]  MEM_in_funct3;
    logic [4:0]  MEM_in_rd;
    logic [31:0] MEM_in_ALU_res, MEM_in_PC_plus4, MEM_in_instr, MEM_mem_data;
    logic        WB_rf_we;
    logic [4:0]  WB_rf_waddr;
    logic [31:0] WB_rf_wdata, WB_instr, WB_retire_cnt;
    logic        WB_halt;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] NOP    = 32'h00000013;

    writeback_stage dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START),
        .MEM_in_valid(MEM_in_valid), .MEM_in_RegWrite(MEM_in_RegWrite),
        .MEM_in_MemToReg(MEM_in_MemToReg), .MEM_in_funct3(MEM_in_funct3),
        .MEM_in_rd(MEM_in_rd), .MEM_in_ALU_res(MEM_in_ALU_res),
        .MEM_in_PC_plus4(MEM_in_PC_plus4), .MEM_in_instr(MEM_in_instr),
        .MEM_mem_data(MEM_mem_data),
        .WB_rf_we(WB_rf_we), .WB_rf_waddr(WB_rf_waddr), .WB_rf_wdata(WB_rf_wdata),
        .WB_instr(WB_instr), .WB_retire_cnt(WB_retire_cnt), .WB_halt(WB_halt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] m2r,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] ins);
        MEM_in_valid    = v;
        MEM_in_RegWrite = rw;
        MEM_in_MemToReg = m2r;
        MEM_in_funct3   = f3;
        MEM_in_rd       = rd;
        MEM_in_ALU_res  = alu;
        MEM_in_PC_plus4 = pc4;
        MEM_in_instr    = ins;
    endtask

    // Clock edge, then present SRAM dout for the cycle after it, then
    // settle at the falling edge where outputs are sampled.
    task automatic step(input logic [31:0] dout);
        @(posedge CLK);
        #1;
        MEM_mem_data = dout;
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; EN = $urandom_range(0, 1); START = $urandom_range(0, 1);
        drive(1'b1, 1'b1, 2'b01, 3'b000, 5'd9, $urandom, $urandom, EBREAK);
        MEM_mem_data = $urandom;

        // Reset for two cycles with random inputs
        step($urandom);
        EN = 1'b1; START = 1'b1;
        drive(1'b1, 1'b1, 2'b10, 3'b001, 5'd17, $urandom, $urandom, EBREAK);
        step($urandom);
        chk("rst_we",    {31'd0, WB_rf_we},   32'd0);
        chk("rst_waddr", {27'd0, WB_rf_waddr}, 32'd0);
        chk("rst_wdata", WB_rf_wdata,          32'd0);
        chk("rst_instr", WB_instr,             32'd0);
        chk("rst_cnt",   WB_retire_cnt,        32'd0);
        chk("rst_halt",  {31'd0, WB_halt},     32'd0);

        RST = 1'b0;
        // Load extension, dout = 80FF7F01
        drive(1'b1, 1'b1, 2'b01, 3'b000, 5'd3, 32'h1D, 32'h0, NOP);   // LB off 1
        step(32'h80FF7F01);
        chk("lb_wdata", WB_rf_wdata, 32'h0000007F);
        chk("lb_we",    {31'd0, WB_rf_we}, 32'd1);
        chk("lb_waddr", {27'd0, WB_rf_waddr}, 32'd3);
        chk("lb_cnt",   WB_retire_cnt, 32'd0);
        drive(1'b1, 1'b1, 2'b01, 3'b100, 5'd3, 32'h1F, 32'h0, NOP);   // LBU off 3
        step(32'h80FF7F01);
        chk("lbu_wdata", WB_rf_wdata, 32'h00000080);
        chk("lbu_cnt",   WB_retire_cnt, 32'd1);
        drive(1'b1, 1'b1, 2'b01, 3'b001, 5'd3, 32'h1E, 32'h0, NOP);   // LH off 2
        step(32'h80FF7F01);
        chk("lh_wdata", WB_rf_wdata, 32'hFFFF80FF);
        drive(1'b1, 1'b1, 2'b01, 3'b010, 5'd3, 32'h1D, 32'h0, NOP);   // LW
        step(32'h80FF7F01);
        chk("lw_wdata", WB_rf_wdata, 32'h80FF7F01);
        drive(1'b1, 1'b1, 2'b01, 3'b101, 5'd3, 32'h1C, 32'h0, NOP);   // LHU off 0
        step(32'h80FF7F01);
        chk("lhu_wdata", WB_rf_wdata, 32'h00007F01);
        drive(1'b1, 1'b1, 2'b01, 3'b000, 5'd3, 32'h1F, 32'h0, NOP);   // LB off 3
        step(32'h80FF7F01);
        chk("lb3_wdata", WB_rf_wdata, 32'hFFFFFF80);
        chk("lb3_cnt",   WB_retire_cnt, 32'd5);

        // Stall after load: dout must stay 2 through the first stalled edge
        drive(1'b1, 1'b1, 2'b01, 3'b010, 5'd5, 32'h40, 32'h0, NOP);
        step(32'h2);
        chk("stl0_wdata", WB_rf_wdata, 32'h2);
        chk("stl0_cnt",   WB_retire_cnt, 32'd6);
        EN = 1'b0;
        step(32'hDEADBEEF);
        chk("stl1_wdata", WB_rf_wdata, 32'h2);
        chk("stl1_we",    {31'd0, WB_rf_we}, 32'd1);
        chk("stl1_cnt",   WB_retire_cnt, 32'd6);
        step(32'hDEADBEEF);
        chk("stl2_wdata", WB_rf_wdata, 32'h2);
        step(32'hDEADBEEF);
        chk("stl3_wdata", WB_rf_wdata, 32'h2);
        chk("stl3_we",    {31'd0, WB_rf_we}, 32'd1);
        chk("stl3_cnt",   WB_retire_cnt, 32'd6);
        EN = 1'b1;

        // Source mux and x0
        drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd7, 32'hAAAA, 32'h104, NOP);
        step(32'h12345678);
        chk("pc4_wdata", WB_rf_wdata, 32'h104);
        chk("pc4_cnt",   WB_retire_cnt, 32'd7);
        drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd0, 32'h1234, 32'h0, NOP);
        step(32'h0);
        chk("x0_we",    {31'd0, WB_rf_we}, 32'd0);
        chk("x0_wdata", WB_rf_wdata, 32'h1234);
        drive(1'b0, 1'b1, 2'b00, 3'b000, 5'd9, 32'h99, 32'h0, NOP);
        step(32'h0);
        chk("bub_we",  {31'd0, WB_rf_we}, 32'd0);
        chk("bub_cnt", WB_retire_cnt, 32'd9);
        drive(1'b1, 1'b1, 2'b11, 3'b000, 5'd10, 32'h55, 32'h77, NOP);
        step(32'h0);
        chk("bub_nocnt", WB_retire_cnt, 32'd9);
        chk("rsv_wdata", WB_rf_wdata, 32'h55);
        chk("rsv_we",    {31'd0, WB_rf_we}, 32'd1);

        // START low also stalls
        START = 1'b0;
        step(32'h0);
        chk("nostart_cnt", WB_retire_cnt, 32'd9);
        START = 1'b1;

        // Halt
        drive(1'b1, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, EBREAK);
        step(32'h0);
        chk("halt_instr", WB_instr, EBREAK);
        chk("halt_pre",   {31'd0, WB_halt}, 32'd0);
        drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd1, 32'h1, 32'h0, NOP);
        step(32'h0);
        chk("halt_set", {31'd0, WB_halt}, 32'd1);
        chk("halt_cnt", WB_retire_cnt, 32'd11);
        step(32'h0);
        chk("halt_sticky", {31'd0, WB_halt}, 32'd1);

        // Wrap: preload the counter as if 2^32-1 instructions had retired
        dut.retire_cnt = 32'hFFFFFFFF;
        step(32'h0);
        chk("wrap_cnt",  WB_retire_cnt, 32'd0);
        chk("wrap_halt", {31'd0, WB_halt}, 32'd1);
        step(32'h0);
        chk("wrap_cnt1", WB_retire_cnt, 32'd1);

        // Reset wins over EN & START, instruction in WB not counted
        RST = 1'b1;
        step(32'h0);
        chk("rst2_cnt",  WB_retire_cnt, 32'd0);
        chk("rst2_halt", {31'd0, WB_halt}, 32'd0);
        chk("rst2_we",   {31'd0, WB_rf_we}, 32'd0);
        chk("rst2_instr", WB_instr, 32'd0);

        // Stall right after reset stays idle with zero outputs
        RST = 1'b0; EN = 1'b0;
        step(32'hFFFFFFFF);
        chk("post_rst_wdata", WB_rf_wdata, 32'd0);
        chk("post_rst_cnt",   WB_retire_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
